// File: rtl/alu_sequencer.sv
// Request/response front end that drives the ALU16 start/s/inbus/outbus/finish
// protocol: clear, load M then Q, collect one or two result words plus flags.
module alu_sequencer #(
  parameter int unsigned W       = 16,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [1:0]   req_op,
  input  logic [W-1:0] req_a,
  input  logic [W-1:0] req_b,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [W-1:0] rsp_hi,
  output logic [W-1:0] rsp_lo,
  output logic [3:0]   rsp_flags,
  output logic         rsp_err,
  output logic         busy,
  output logic         alu_rst_b,
  output logic         alu_start,
  output logic [1:0]   alu_s,
  output logic [W-1:0] alu_inbus,
  input  logic [W-1:0] alu_outbus,
  input  logic         alu_finish,
  input  logic         alu_negative,
  input  logic         alu_zero,
  input  logic         alu_carry,
  input  logic         alu_overflow
);

  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_CLR, S_SETUP, S_LOADM, S_LOADQ, S_WAIT, S_WAIT2, S_DONE
  } state_t;

  state_t         state_q, state_d;
  logic [1:0]     op_q, op_d;
  logic [W-1:0]   a_q, a_d, b_q, b_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [W-1:0]   hi_d, lo_d, inbus_d;
  logic [3:0]     flags_d;
  logic           err_d, start_d, rstb_d;
  logic [1:0]     s_d;

  // Next state, captured result fields, and ALU drive for the state being entered.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    hi_d    = rsp_hi;
    lo_d    = rsp_lo;
    flags_d = rsp_flags;
    err_d   = rsp_err;
    rstb_d  = 1'b1;
    start_d = 1'b0;
    s_d     = 2'b00;
    inbus_d = '0;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          op_d    = req_op;
          a_d     = req_a;
          b_d     = req_b;
          state_d = S_CLR;
        end
      end
      S_CLR:   state_d = S_SETUP;
      S_SETUP: state_d = S_LOADM;
      S_LOADM: state_d = S_LOADQ;
      S_LOADQ: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (alu_finish) begin
          flags_d = {alu_negative, alu_zero, alu_carry, alu_overflow};
          err_d   = 1'b0;
          if (op_q[1]) begin
            hi_d    = alu_outbus;
            state_d = S_WAIT2;
          end else begin
            hi_d    = '0;
            lo_d    = alu_outbus;
            state_d = S_DONE;
          end
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          hi_d    = '0;
          lo_d    = '0;
          flags_d = '0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      // The second word must follow the first back-to-back.
      S_WAIT2: begin
        if (alu_finish) begin
          lo_d = alu_outbus;
        end else begin
          err_d = 1'b1;
          lo_d  = '0;
        end
        state_d = S_DONE;
      end
      S_DONE: begin
        if (rsp_ready) begin
          err_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    case (state_d)
      S_CLR: begin
        rstb_d = 1'b0;
        s_d    = op_d;
      end
      S_SETUP: s_d = op_d;
      S_LOADM: begin
        start_d = 1'b1;
        s_d     = op_d;
        inbus_d = a_d;
      end
      S_LOADQ, S_WAIT, S_WAIT2: begin
        s_d     = op_d;
        inbus_d = b_d;
      end
      default: ;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      cnt_q     <= '0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_hi    <= '0;
      rsp_lo    <= '0;
      rsp_flags <= '0;
      rsp_err   <= 1'b0;
      busy      <= 1'b0;
      alu_rst_b <= 1'b1;
      alu_start <= 1'b0;
      alu_s     <= 2'b00;
      alu_inbus <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      cnt_q     <= cnt_d;
      req_ready <= (state_d == S_IDLE);
      rsp_valid <= (state_d == S_DONE);
      rsp_hi    <= hi_d;
      rsp_lo    <= lo_d;
      rsp_flags <= flags_d;
      rsp_err   <= err_d;
      busy      <= (state_d != S_IDLE);
      alu_rst_b <= rstb_d;
      alu_start <= start_d;
      alu_s     <= s_d;
      alu_inbus <= inbus_d;
    end
  end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Initiator for the ALU16 `start`/`s`/`inbus`/`outbus`/`finish` protocol.
- Accepts one operation request (op, two operands) over a valid/ready handshake.
- Clears the ALU, then serialises the operands onto the ALU input bus: M word first, Q word second.
- Collects the one-word (add/sub) or two-word (mul/div) result plus flags and returns it over a valid/ready response handshake. The control unit uses it in place of a hand-sequenced ALU drive.

Parameters:
- W, 16: datapath width; must match the ALU.
- TIMEOUT, 64: cycles allowed in WAIT for first `alu_finish`.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE.
- req_op  in  2  00 add, 01 sub, 10 mul, 11 div.
- req_a  in  W  first operand, driven as M word.
- req_b  in  W  second operand, driven as Q word.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed.
- rsp_hi  out  W  high word / remainder; 0 for add/sub.
- rsp_lo  out  W  low word / sum / difference / quotient.
- rsp_flags  out  4  {negative, zero, carry, overflow} captured from ALU.
- rsp_err  out  1  timeout occurred.
- busy  out  1  state != IDLE.
- alu_rst_b  out  1  ALU reset, active-low.
- alu_start  out  1  ALU start.
- alu_s  out  2  ALU op select.
- alu_inbus  out  W  ALU input bus.
- alu_outbus  in  W  ALU result bus.
- alu_finish  in  1  ALU result-word strobe.
- alu_negative, alu_zero, alu_carry, alu_overflow  in  1 each  ALU flags.

Behaviour:
- Reset values (state IDLE):
  - req_ready=1.
  - rsp_valid=0, rsp_hi=0, rsp_lo=0, rsp_flags=0, rsp_err=0, busy=0.
  - alu_rst_b=1, alu_start=0, alu_s=0, alu_inbus=0.
  - Reset in any state aborts the operation immediately; the pending response is lost; no ALU strobes follow.
- Request acceptance: when req_valid and req_ready are both high, latch op, a, b and go to CLR. Registered op drives alu_s from CLR through WAIT, held constant.
- States, one transition per clk:
  - IDLE: accept as above.
  - CLR: alu_rst_b=0, alu_start=0, alu_inbus=0; next SETUP.
  - SETUP: alu_rst_b=1; next LOADM.
  - LOADM: alu_start=1, alu_inbus=a; next LOADQ.
  - LOADQ: alu_start=0, alu_inbus=b; next WAIT. Clear timeout counter.
  - WAIT: alu_inbus holds b.
    - On alu_finish: capture alu_outbus and the four flags.
    - If op is add/sub: rsp_lo=captured word, rsp_hi=0; next DONE.
    - If op is mul/div: captured word goes to rsp_hi; next WAIT2.
    - Counter increments each WAIT cycle without finish. At count==TIMEOUT-1 with no finish: rsp_err=1, rsp_hi=0, rsp_lo=0, rsp_flags=0; next DONE.
  - WAIT2: the ALU asserts alu_finish on the cycle immediately following the first word.
    - If alu_finish: rsp_lo=alu_outbus; next DONE.
    - If finish absent: rsp_err=1, rsp_lo=0, rsp_hi keeps the first word; next DONE.
  - DONE: rsp_valid=1; outputs stable. When rsp_ready is high: rsp_valid=0, rsp_err=0; next IDLE. rsp_hi/rsp_lo/rsp_flags hold until the next capture.
- Latency: minimum 6 cycles from accept to rsp_valid for add/sub with finish on the first WAIT cycle; one more cycle for mul/div.
- Spurious inputs: alu_finish in IDLE, CLR, SETUP, LOADM, LOADQ or DONE is ignored.
- Back-to-back: req_ready=0 until the DONE handshake completes, so there is at most one operation in flight. A new request is accepted no earlier than the cycle after returning to IDLE.
- Flags are taken only from the first finish cycle, never recomputed.

Test Plan:
- Add: req_op=00, a=2147, b=5; ALU asserts finish with 2152 → rsp_lo=2152, rsp_hi=0, rsp_flags=0000, rsp_err=0. Verify alu_start is high exactly one cycle with alu_inbus=2147, followed by alu_inbus=5.
- Sub overflow: op=01, a=1, b=0x8000 → rsp_lo=0x7FFF, overflow flag=1, rsp_hi=0.
- Mul: op=10, a=2350, b=159; ALU returns 0x0005 then 0xB392 → rsp_hi=0x0005, rsp_lo=0xB392, rsp_valid high exactly 1 cycle after the second finish.
- Div with backpressure: op=11, a=145, b=18921; rsp_ready held low 10 cycles → rsp_hi=71, rsp_lo=130, rsp_valid steady throughout, req_ready=0 until the handshake.
- Timeout: op=00, bench never asserts finish → rsp_valid after TIMEOUT WAIT cycles, rsp_err=1, rsp_lo=0. The next request completes normally.
- Reset mid-op: rst high during LOADQ → next cycle IDLE, alu_start=0, alu_inbus=0, rsp_valid=0, req_ready=1.
